// File: rtl/conv_stream_feeder_pkg.sv
// conv_feeder_pkg: shared constants, widths and FSM state type for the
// convolution stream feeder (frame geometry, data widths, timeout budget).
package conv_feeder_pkg;

  // Frame geometry: 14x14 IFM, 3x3 weights, 6x6 pooled results.
  localparam int unsigned IFM_WORDS = 196;
  localparam int unsigned W_WORDS   = 9;
  localparam int unsigned RES_WORDS = 36;

  // Idle cycles tolerated while waiting for engine results.
  localparam int unsigned TIMEOUT   = 1023;

  // Data and address widths.
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned RES_W     = 36;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned WIDX_W    = 4;
  localparam int unsigned RADDR_W   = 6;
  localparam int unsigned TCNT_W    = 10;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    COLLECT,
    DONE
  } state_t;

endpackage

// File: rtl/conv_stream_feeder_if.sv
// conv_stream_feeder_if: stream link between the feeder and the convolution
// engine.
//   in_valid / In_IFM / In_Weight : feeder -> engine input stream
//   out_valid / Out_OFM           : engine -> feeder pooled results
// Modports: master = feeder side, slave = engine side.
interface conv_stream_feeder_if;
  import conv_feeder_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] In_IFM;
  logic [DATA_W-1:0] In_Weight;
  logic              out_valid;
  logic [RES_W-1:0]  Out_OFM;

  modport master (
    output in_valid,
    output In_IFM,
    output In_Weight,
    input  out_valid,
    input  Out_OFM
  );

  modport slave (
    input  in_valid,
    input  In_IFM,
    input  In_Weight,
    output out_valid,
    output Out_OFM
  );

endinterface

// File: rtl/conv_stream_feeder_result_buf.sv
// conv_result_buf: 36 x 36-bit result register file.
//   clk, rst_n    : clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata: capture write port
//   raddr/rdata   : registered read port; out-of-range addresses read as 0
// A read and a write to the same address in one cycle return the old word.
module conv_result_buf
  import conv_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [RES_W-1:0]   wdata,
  input  logic [RADDR_W-1:0] raddr,
  output logic [RES_W-1:0]   rdata
);

  // Storage is deliberately not reset; uncaptured entries keep old contents.
  logic [RES_W-1:0] mem [RES_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (raddr < RADDR_W'(RES_WORDS)) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: loads one IFM frame and weight set from the host,
// streams them to the convolution engine, collects the 36 pooled results
// and exposes them through a registered read port.
//   clk, rst_n                        : clock, async active-low reset
//   wr_en/wr_sel/wr_addr/wr_data      : host buffer write (IDLE only)
//   start                             : frame start pulse (IDLE only)
//   rd_addr/rd_data                   : result read port, 1-cycle latency
//   busy/done/err_timeout             : frame status
//   eng                               : engine stream link (master side)
module conv_stream_feeder
  import conv_feeder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 start,
  input  logic [RADDR_W-1:0]   rd_addr,
  output logic [RES_W-1:0]     rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  conv_stream_feeder_if.master eng
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  k_q;
  logic [RADDR_W-1:0] n_q;
  logic [TCNT_W-1:0]  tcnt_q;

  logic               capture;
  logic               timeout_hit;
  logic               wr_ifm;
  logic               wr_w;

  logic [DATA_W-1:0]  ifm [IFM_WORDS];
  logic [DATA_W-1:0]  w   [W_WORDS];

  logic [ADDR_W-1:0]  fetch_idx;
  logic [DATA_W-1:0]  fetch_ifm;
  logic [DATA_W-1:0]  fetch_w;

  // Host writes, accepted only in IDLE and only for in-range addresses.
  always_comb begin
    wr_ifm = (state_q == IDLE) && wr_en && !wr_sel && (wr_addr < ADDR_W'(IFM_WORDS));
    wr_w   = (state_q == IDLE) && wr_en &&  wr_sel && (wr_addr < ADDR_W'(W_WORDS));
  end

  always_ff @(posedge clk) begin
    if (wr_ifm) begin
      ifm[wr_addr] <= wr_data;
    end
    if (wr_w) begin
      w[wr_addr[WIDX_W-1:0]] <= wr_data;
    end
  end

  // Output words are registered, so the word for k+1 is fetched while word k
  // is on the bus; the start edge fetches word 0. A write landing on address
  // 0 in the start cycle is forwarded so the stream carries the new value.
  always_comb begin
    fetch_idx = (state_q == IDLE) ? '0 : k_q + 1'b1;
    fetch_ifm = '0;
    fetch_w   = '0;
    if (fetch_idx < ADDR_W'(IFM_WORDS)) begin
      fetch_ifm = ifm[fetch_idx];
    end
    if (fetch_idx < ADDR_W'(W_WORDS)) begin
      fetch_w = w[fetch_idx[WIDX_W-1:0]];
    end
    if (state_q == IDLE && wr_en && wr_addr == '0) begin
      if (!wr_sel) begin
        fetch_ifm = wr_data;
      end else begin
        fetch_w = wr_data;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (k_q == ADDR_W'(IFM_WORDS - 1)) begin
          state_d = WAIT;
        end
      end
      WAIT, COLLECT: begin
        if (eng.out_valid) begin
          capture = 1'b1;
          state_d = (n_q == RADDR_W'(RES_WORDS - 1)) ? DONE : COLLECT;
        end else if (tcnt_q == TCNT_W'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      n_q           <= '0;
      tcnt_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      eng.in_valid  <= 1'b0;
      eng.In_IFM    <= '0;
      eng.In_Weight <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            err_timeout   <= 1'b0;
            n_q           <= '0;
            k_q           <= '0;
            eng.in_valid  <= 1'b1;
            eng.In_IFM    <= fetch_ifm;
            eng.In_Weight <= fetch_w;
          end
        end
        SEND: begin
          if (k_q == ADDR_W'(IFM_WORDS - 1)) begin
            eng.in_valid  <= 1'b0;
            eng.In_IFM    <= '0;
            eng.In_Weight <= '0;
            tcnt_q        <= '0;
          end else begin
            k_q           <= k_q + 1'b1;
            eng.In_IFM    <= fetch_ifm;
            eng.In_Weight <= fetch_w;
          end
        end
        WAIT, COLLECT: begin
          if (capture) begin
            n_q    <= n_q + 1'b1;
            tcnt_q <= '0;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  conv_result_buf u_res_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (capture),
    .waddr (n_q),
    .wdata (eng.Out_OFM),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Self-checking bench for conv_stream_feeder: behavioural buffer/result model,
// randomized data and engine response gaps.
module tb_conv_stream_feeder;
  import conv_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [35:0] rd_data;
  logic        busy;
  logic        done;
  logic        err_timeout;

  conv_stream_feeder_if eng();

  conv_stream_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .eng         (eng)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the host-visible buffers.
  logic [15:0] ifm_m [IFM_WORDS];
  logic [15:0] w_m   [W_WORDS];
  logic [35:0] res_m [RES_WORDS];

  // Observations from the most recent frame.
  logic [15:0] obs_ifm [$];
  logic [15:0] obs_w   [$];
  int          done_cnt;
  int          done_gap;
  logic        err_first;
  logic        busy_first;
  logic        busy_after;

  // All tasks start and end just after a falling edge.
  task automatic write_word(input logic sel, input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    if (!sel && int'(a) < int'(IFM_WORDS)) ifm_m[a] = d;
    if (sel && int'(a) < int'(W_WORDS)) w_m[a[3:0]] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_res(input logic [5:0] a, output logic [35:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  function automatic logic [35:0] exp_read(input logic [5:0] a);
    return (int'(a) < int'(RES_WORDS)) ? res_m[a] : 36'h0;
  endfunction

  // First index where the observed stream deviates from the model, -1 if none.
  function automatic int stream_err();
    for (int unsigned k = 0; k < IFM_WORDS; k++) begin
      if (obs_ifm[k] !== ifm_m[k]) return int'(k);
      if (obs_w[k] !== ((k < W_WORDS) ? w_m[k] : 16'h0)) return int'(k);
    end
    return -1;
  endfunction

  // Runs one frame: start pulse (optionally with a write to ifm[0]), records
  // the stream, plays an engine returning nres words base+n with gaps of 0..5
  // cycles, and optionally injects start+write at cycle inj during the frame.
  task automatic run_frame(input int nres, input logic [35:0] base,
                           input logic sw_en, input logic [15:0] sw_data, input int inj);
    int   cyc = 0;
    int   sent = 0;
    int   gap_left;
    int   last_cap = -1;
    int   done_cyc = -1;
    logic stream_over = 1'b0;
    obs_ifm.delete();
    obs_w.delete();
    done_cnt = 0;
    busy_after = 1'bx;
    start = 1'b1;
    if (sw_en) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = sw_data;
      ifm_m[0] = sw_data;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    gap_left = int'($urandom_range(0, 5)) + 2;
    while (cyc < 3000) begin
      if (cyc == 0) begin
        err_first  = err_timeout;
        busy_first = busy;
      end
      if (eng.in_valid) begin
        obs_ifm.push_back(eng.In_IFM);
        obs_w.push_back(eng.In_Weight);
      end else if (obs_ifm.size() > 0) begin
        stream_over = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      start = 1'b0; wr_en = 1'b0;
      if (cyc == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 16'hFFFF;
      end
      eng.out_valid = 1'b0;
      if (stream_over && sent < nres) begin
        if (gap_left == 0) begin
          eng.out_valid = 1'b1;
          eng.Out_OFM   = base + 36'(sent);
          res_m[sent]   = base + 36'(sent);
          sent++;
          last_cap = cyc + 1;
          gap_left = int'($urandom_range(0, 5));
        end else begin
          gap_left--;
        end
      end
      @(negedge clk);
      cyc++;
    end
    eng.out_valid = 1'b0;
    start = 1'b0; wr_en = 1'b0;
    done_gap = (done_cyc >= 0) ? done_cyc - last_cap : -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (eng.in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid: got %b want 0", eng.in_valid); end
    checks++; if (eng.In_IFM !== 16'h0) begin errors++; $display("FAIL reset_In_IFM: got %h want 0", eng.In_IFM); end
    checks++; if (eng.In_Weight !== 16'h0) begin errors++; $display("FAIL reset_In_Weight: got %h want 0", eng.In_Weight); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    checks++; if (rd_data !== 36'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream_pattern();
    logic [35:0] d;
    int e;
    for (int unsigned i = 0; i < IFM_WORDS; i++) write_word(1'b0, 8'(i), 16'(i));
    for (int unsigned j = 0; j < W_WORDS; j++) write_word(1'b1, 8'(j), 16'(j + 1));
    run_frame(36, 36'd100, 1'b0, 16'h0, -1);
    checks++; if (obs_ifm.size() != 196) begin errors++; $display("FAIL pat_stream_len: got %0d want 196", obs_ifm.size()); end
    e = (obs_ifm.size() == 196) ? stream_err() : 0;
    checks++; if (e != -1) begin errors++; $display("FAIL pat_stream_data: first bad k=%0d", e); end
    checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL pat_busy: got %b want 1", busy_first); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL pat_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_gap != 0) begin errors++; $display("FAIL pat_done_lat: got %0d want 0", done_gap); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL pat_busy_after: got %b want 0", busy_after); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL pat_err: got %b want 0", err_timeout); end
    read_res(6'd0, d);
    checks++; if (d !== 36'd100) begin errors++; $display("FAIL pat_rd0: got %0d want 100", d); end
    read_res(6'd35, d);
    checks++; if (d !== 36'd135) begin errors++; $display("FAIL pat_rd35: got %0d want 135", d); end
  endtask

  task automatic test_timeout();
    logic [35:0] d;
    run_frame(20, 36'd100, 1'b0, 16'h0, -1);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL to_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_gap != 1024) begin errors++; $display("FAIL to_done_lat: got %0d want 1024", done_gap); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err_timeout); end
    read_res(6'd19, d);
    checks++; if (d !== 36'd119) begin errors++; $display("FAIL to_rd19: got %0d want 119", d); end
    read_res(6'd35, d);
    checks++; if (d !== exp_read(6'd35)) begin errors++; $display("FAIL to_rd35_kept: got %0d want %0d", d, exp_read(6'd35)); end
  endtask

  task automatic test_ignored_in_send();
    int e;
    run_frame(36, 36'd500, 1'b0, 16'h0, 50);
    checks++; if (err_first !== 1'b0) begin errors++; $display("FAIL ign_err_cleared: got %b want 0", err_first); end
    e = (obs_ifm.size() == 196) ? stream_err() : 0;
    checks++; if (e != -1) begin errors++; $display("FAIL ign_stream: first bad k=%0d len=%0d", e, obs_ifm.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL ign_err: got %b want 0", err_timeout); end
  endtask

  task automatic test_invalid_writes();
    logic [35:0] d;
    int e;
    write_word(1'b0, 8'd200, 16'($urandom()));
    write_word(1'b1, 8'd9, 16'($urandom()));
    read_res(6'd40, d);
    checks++; if (d !== 36'h0) begin errors++; $display("FAIL inv_rd40: got %h want 0", d); end
    run_frame(36, 36'd700, 1'b0, 16'h0, -1);
    checks++; if (obs_ifm.size() == 0 || obs_ifm[0] !== 16'h0) begin errors++; $display("FAIL inv_ifm0: got %h want 0", (obs_ifm.size() > 0) ? obs_ifm[0] : 16'hxxxx); end
    e = (obs_ifm.size() == 196) ? stream_err() : 0;
    checks++; if (e != -1) begin errors++; $display("FAIL inv_stream: first bad k=%0d", e); end
  endtask

  task automatic test_start_with_write();
    logic [15:0] v;
    int e;
    v = 16'($urandom()) | 16'h0001;
    run_frame(36, 36'd900, 1'b1, v, -1);
    checks++; if (obs_ifm.size() == 0 || obs_ifm[0] !== v) begin errors++; $display("FAIL sww_ifm0: got %h want %h", (obs_ifm.size() > 0) ? obs_ifm[0] : 16'hxxxx, v); end
    e = (obs_ifm.size() == 196) ? stream_err() : 0;
    checks++; if (e != -1) begin errors++; $display("FAIL sww_stream: first bad k=%0d", e); end
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0;
    int guard = 0;
    int e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (guard < 400) begin
      if (eng.in_valid) begin
        if (seen == 100) break;
        seen++;
      end
      @(negedge clk);
      guard++;
    end
    checks++; if (eng.In_IFM !== ifm_m[100] || seen != 100) begin errors++; $display("FAIL mid_k100: got %h want %h seen=%0d", eng.In_IFM, ifm_m[100], seen); end
    rst_n = 1'b0;
    #1;
    checks++; if (eng.in_valid !== 1'b0) begin errors++; $display("FAIL mid_in_valid: got %b want 0", eng.in_valid); end
    checks++; if (eng.In_IFM !== 16'h0 || eng.In_Weight !== 16'h0) begin errors++; $display("FAIL mid_data: got %h/%h want 0/0", eng.In_IFM, eng.In_Weight); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_busy_done: got %b/%b want 0/0", busy, done); end
    checks++; if (err_timeout !== 1'b0 || rd_data !== 36'h0) begin errors++; $display("FAIL mid_err_rd: got %b/%h want 0/0", err_timeout, rd_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after_release: got done=%b busy=%b want 0/0", done, busy); end
    run_frame(36, 36'd1300, 1'b0, 16'h0, -1);
    e = (obs_ifm.size() == 196) ? stream_err() : 0;
    checks++; if (e != -1) begin errors++; $display("FAIL mid_restream: first bad k=%0d len=%0d", e, obs_ifm.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL mid_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_frames();
    logic [35:0] d;
    logic [5:0]  a;
    int e;
    for (int unsigned f = 0; f < 2; f++) begin
      for (int unsigned i = 0; i < IFM_WORDS; i++) write_word(1'b0, 8'(i), 16'($urandom()));
      for (int unsigned j = 0; j < W_WORDS; j++) write_word(1'b1, 8'(j), 16'($urandom()));
      run_frame(36, {4'h0, 32'($urandom())}, 1'b0, 16'h0, -1);
      e = (obs_ifm.size() == 196) ? stream_err() : 0;
      checks++; if (e != -1) begin errors++; $display("FAIL rnd_stream: frame %0d first bad k=%0d len=%0d", f, e, obs_ifm.size()); end
      checks++; if (done_cnt != 1 || done_gap != 0) begin errors++; $display("FAIL rnd_done: frame %0d cnt=%0d lat=%0d want 1/0", f, done_cnt, done_gap); end
      for (int unsigned r = 0; r < 4; r++) begin
        a = 6'($urandom_range(0, 47));
        read_res(a, d);
        checks++; if (d !== exp_read(a)) begin errors++; $display("FAIL rnd_read: addr %0d got %h want %h", a, d, exp_read(a)); end
      end
    end
  endtask

  initial begin
    eng.out_valid = 1'b0;
    eng.Out_OFM   = '0;
    test_reset();
    test_stream_pattern();
    test_timeout();
    test_ignored_in_send();
    test_invalid_writes();
    test_start_with_write();
    test_reset_mid_frame();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_stream_feeder.md
# conv_stream_feeder

Streaming driver and result collector for the 14x14 / 3x3 convolution-with-pooling engine. The host loads one 14x14 IFM and one 3x3 weight set through a write port and pulses `start`. The block then drives the engine's `in_valid`/`In_IFM`/`In_Weight` stream, captures the 36 pooled results returned on `out_valid`/`Out_OFM`, and exposes them through a read port. It sits between the host/testbench and the convolution engine.

## Interface
- `IFM_WORDS`, 196: IFM words streamed per frame (14x14, raster order).
- `W_WORDS`, 9: weight words, row-major 3x3.
- `RES_WORDS`, 36: pooled results expected per frame (6x6).
- `TIMEOUT`, 1023: maximum idle cycles without `out_valid` while waiting for results.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: host write strobe.
- `wr_sel` in 1: write target, 0 = IFM buffer, 1 = weight buffer.
- `wr_addr` in 8: word address.
- `wr_data` in 16: write data.
- `start` in 1: single-cycle frame start request.
- `rd_addr` in 6: result read address.
- `rd_data` out 36: result word, registered.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle frame-complete pulse.
- `err_timeout` out 1: sticky, set when a frame ends by timeout.
- `in_valid` out 1: engine input valid.
- `In_IFM` out 16: engine IFM data.
- `In_Weight` out 16: engine weight data.
- `out_valid` in 1: engine result valid.
- `Out_OFM` in 36: engine result data.

## Operation
- States: IDLE, SEND, WAIT, COLLECT, DONE.
- **IDLE.** `wr_en` writes `wr_data` into `ifm[wr_addr]` (`wr_sel`=0) or `w[wr_addr]` (`wr_sel`=1).
  - Writes with `wr_addr` >= 196 (IFM) or >= 9 (weight) are dropped.
  - `start`=1 clears `err_timeout`, clears the result count, and moves to SEND.
- **SEND.** Stream counter k runs 0..195, one word per cycle with no gaps. Each cycle drives `in_valid`=1, `In_IFM`=`ifm[k]`, and `In_Weight`=`w[k]` for k<9, else 0. After k=195 the block moves to WAIT.
- **WAIT / COLLECT.**
  - Each cycle with `out_valid`=1 stores `Out_OFM` at full 36-bit width into `res[n]`, increments n, and reloads the timeout counter. The first capture moves WAIT to COLLECT.
  - Gaps in `out_valid` are legal.
  - Capturing n=35 moves to DONE.
  - If the timeout counter reaches `TIMEOUT` with no `out_valid`: set `err_timeout` and move to DONE. `res` entries not yet captured keep their previous contents.
- **DONE.** `done`=1 for one cycle, then return to IDLE.
- **Ignored inputs:**
  - `wr_en` and `start` are ignored outside IDLE.
  - `out_valid` is ignored in IDLE, SEND and DONE, and after 36 captures.
- **Read port.** `rd_data` <= `res[rd_addr]` every cycle. Addresses >= 36 return 0. Reading is legal in every state.

## Timing
- Reset values: `in_valid`, `In_IFM`, `In_Weight`, `busy`, `done`, `err_timeout` and `rd_data` are all 0; state is IDLE; counters are 0.
- The `ifm`, `w` and `res` arrays are not reset.
- All outputs are registered.
- `start` sampled high at edge T: `busy` and `in_valid` go high after T. The first word (k=0) is valid in cycle T+1, and `in_valid` falls after cycle T+196.
- `busy` stays high from T+1 through the DONE cycle inclusive. It is low in the cycle after `done`.
- `done` rises on the edge following the 36th capture, or the edge following the timeout count.
- `start` in the same cycle as `wr_en` in IDLE: the write is performed and the stream uses the new value.
- `rd_data` latency is 1 cycle. If a read and a capture hit the same address in the same cycle, `rd_data` returns the old value.
- Reset asserted mid-frame: outputs drop to their reset values immediately and the state returns to IDLE. No `done` is produced.
- Timeout counter: 10 bits, reloaded to 0 on SEND→WAIT and on each capture.

## Structure
- Package `conv_feeder_pkg` holds:
  - the state enum;
  - constants `IFM_WORDS`, `W_WORDS`, `RES_WORDS` and `TIMEOUT`;
  - the data widths 16 and 36.
- Sub-module `conv_result_buf` is a 36x36 register file with one write port (capture) and one registered read port (returns 0 for out-of-range addresses).
- IFM/weight storage and the FSM live in the top module.

## Test plan
- Load `ifm[i]`=i and `w[j]`=j+1, then pulse `start`:
  - `in_valid` is high for exactly 196 cycles.
  - `In_IFM` follows 0..195.
  - `In_Weight` follows 1..9 and is then 0 for the remaining 187 cycles.
- Engine model returns `Out_OFM`=100+n for n=0..35 with a random gap of 0–5 cycles between words:
  - `done` pulses once.
  - `rd_addr`=0/35 reads 100/135.
  - `err_timeout`=0.
- Engine model returns only 20 words:
  - `done` pulses exactly 1024 cycles after the last capture.
  - `err_timeout`=1.
  - `res[19]`=119.
  - The next `start` clears `err_timeout`.
- During SEND, issue `start` and `wr_en` (`wr_addr`=0, `wr_data`=0xFFFF):
  - Both are ignored and the stream is unchanged.
  - A later frame still streams `ifm[0]`=0.
- Assert `rst_n`=0 at k=100:
  - All outputs are 0 immediately.
  - After release, a fresh `start` restreams from k=0.
- Write with `wr_addr`=200 (IFM) and `wr_addr`=9 (weight):
  - No buffer changes.
  - Reading `rd_addr`=40 returns 0.
